shared_res_arbiter: RTL and testbench

- Arbitrates the single shared resource between pipeline 1 and pipeline 2 under the global-stall scheme.
- Issues one operation at a time, tracks the in-flight owner and returns the result to that owner only.
- Generates stall_1/stall_2 back to the pipelines and handles flush of the owning pipeline mid-operation.
- Sits inside pipeline_wrapped, between the two pipeline stages and the shared resource.

---
 rtl/shared_res_arbiter_pkg.sv | 14 +
 rtl/rr_arbiter2.sv | 31 +++
 rtl/shared_res_arbiter.sv | 117 +++++++++++
 tb/tb_shared_res_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_res_arbiter_pkg.sv
// Shared types and constants for the shared-resource arbiter.
package shared_res_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned REQ_P1     = 0;
  localparam int unsigned REQ_P2     = 1;
  localparam int unsigned DATA_W_DEF = 32;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin picker; pointer remembers the last winner.
module rr_arbiter2
  import shared_res_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  // Set when pipeline 2 won last; reset value makes pipeline 1 win first.
  logic last_p2;

  // One-hot pick: a lone requester wins, a tie goes to the one not granted last.
  always_comb begin
    gnt = req;
    if (req[REQ_P1] && req[REQ_P2]) begin
      gnt = '0;
      if (last_p2) gnt[REQ_P1] = 1'b1;
      else         gnt[REQ_P2] = 1'b1;
    end
  end

  // Pointer follows every grant actually taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 last_p2 <= 1'b1;
    else if (update && |gnt) last_p2 <= gnt[REQ_P2];
  end

endmodule

// File: rtl/shared_res_arbiter.sv
// Arbitrates one shared resource between two stalled pipelines: issue,
// ownership tracking, result return, flush draining and latency timeout.
module shared_res_arbiter
  import shared_res_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned MAX_LAT = 8,
  parameter int unsigned CNT_W   = 4
)(
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [DATA_W-1:0] req_data_1,
  input  logic [DATA_W-1:0] req_data_2,
  input  logic              flush_1,
  input  logic              flush_2,
  output logic              res_start,
  output logic [DATA_W-1:0] res_data,
  input  logic              res_done,
  input  logic [DATA_W-1:0] res_result,
  output logic [1:0]        grant,
  output logic              stall_1,
  output logic              stall_2,
  output logic [1:0]        resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              timeout
);

  state_t             state, state_next;
  logic [1:0]         eff_req;
  logic [1:0]         pick;
  logic [CNT_W-1:0]   lat_cnt;
  logic               issue;
  logic               owner_flush;
  logic               lat_expired;

  assign eff_req     = req & ~{flush_2, flush_1};
  assign owner_flush = (grant[REQ_P1] & flush_1) | (grant[REQ_P2] & flush_2);
  // >= rather than == so a flush landing on the last cycle still times out in DRAIN.
  assign lat_expired = (lat_cnt >= CNT_W'(MAX_LAT));
  assign resp_data   = res_result;
  assign stall_1     = req[REQ_P1] & ~flush_1 & ~resp_valid[REQ_P1];
  assign stall_2     = req[REQ_P2] & ~flush_2 & ~resp_valid[REQ_P2];

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst    (reset),
    .req    (eff_req),
    .update (issue),
    .gnt    (pick)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state plus combinational completion/timeout outputs.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    resp_valid = '0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (|eff_req) begin
          issue      = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (res_done) begin
          if (!owner_flush) resp_valid = grant;
          state_next = IDLE;
        end else if (owner_flush) begin
          state_next = DRAIN;
        end else if (lat_expired) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      DRAIN: begin
        if (res_done) begin
          state_next = IDLE;
        end else if (lat_expired) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Issue registers, owner tracking and the saturating latency counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant     <= '0;
      res_start <= 1'b0;
      res_data  <= '0;
      lat_cnt   <= '0;
    end else begin
      res_start <= issue;
      if (issue) begin
        grant    <= pick;
        res_data <= pick[REQ_P2] ? req_data_2 : req_data_1;
        lat_cnt  <= '0;
      end else if (state_next == IDLE) begin
        grant   <= '0;
        lat_cnt <= '0;
      end else if (lat_cnt != '1) begin
        lat_cnt <= lat_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_shared_res_arbiter.sv
// Self-checking bench for shared_res_arbiter with a transaction-level model.
module tb_shared_res_arbiter;

  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    req = '0;
  logic [1:0]    flush = '0;
  logic [DW-1:0] req_data_1 = '0, req_data_2 = '0;
  logic          res_done = 1'b0;
  logic [DW-1:0] res_result = '0;
  logic          res_start, timeout, stall_1, stall_2;
  logic [DW-1:0] res_data, resp_data;
  logic [1:0]    grant, resp_valid, st;

  int n_checks = 0;
  int n_fail   = 0;
  int model_last = 1;  // requester granted most recently (1 => pipeline 1 wins a tie)

  assign st = {stall_2, stall_1};

  shared_res_arbiter #(.DATA_W(DW), .MAX_LAT(LAT), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .req(req),
    .req_data_1(req_data_1), .req_data_2(req_data_2),
    .flush_1(flush[0]), .flush_2(flush[1]),
    .res_start(res_start), .res_data(res_data),
    .res_done(res_done), .res_result(res_result),
    .grant(grant), .stall_1(stall_1), .stall_2(stall_2),
    .resp_valid(resp_valid), .resp_data(resp_data), .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int exp_winner(input logic [1:0] er);
    if (er == 2'b11) return (model_last == 0) ? 1 : 0;
    return er[0] ? 0 : 1;
  endfunction

  // Runs one operation from an idle cycle whose inputs are already applied.
  task automatic serve_op(input string tag, input int lat, input logic keep, output int o);
    logic [1:0] g;
    logic [DW-1:0] d, r;
    int oth;
    o   = exp_winner(req & ~flush);
    oth = 1 - o;
    g   = (o == 0) ? 2'b01 : 2'b10;
    d   = $urandom;
    r   = $urandom;
    if (o == 0) req_data_1 = d; else req_data_2 = d;
    @(negedge clk); #1;
    if ({grant, res_start, resp_valid} !== {g, 1'b1, 2'b00}) begin
      $display("FAIL %s_issue: grant/start/valid got %b expected %b", tag, {grant, res_start, resp_valid}, {g, 1'b1, 2'b00}); n_fail++;
    end
    n_checks++;
    if (res_data !== d) begin
      $display("FAIL %s_res_data: got %h expected %h", tag, res_data, d); n_fail++;
    end
    n_checks++;
    model_last = o;
    for (int k = 1; k < lat; k++) begin
      @(negedge clk); #1;
      if ({grant, res_start, resp_valid, timeout, st[o]} !== {g, 1'b0, 2'b00, 1'b0, 1'b1}) begin
        $display("FAIL %s_busy: grant/start/valid/timeout/stall got %b expected %b", tag, {grant, res_start, resp_valid, timeout, st[o]}, {g, 1'b0, 2'b00, 1'b0, 1'b1}); n_fail++;
      end
      n_checks++;
    end
    @(negedge clk); res_done = 1'b1; res_result = r; #1;
    if ({resp_valid, timeout, st[o], st[oth]} !== {g, 1'b0, 1'b0, req[oth] & ~flush[oth]}) begin
      $display("FAIL %s_done: valid/timeout/stall_own/stall_oth got %b expected %b", tag, {resp_valid, timeout, st[o], st[oth]}, {g, 1'b0, 1'b0, req[oth] & ~flush[oth]}); n_fail++;
    end
    n_checks++;
    if (resp_data !== r) begin
      $display("FAIL %s_resp_data: got %h expected %h", tag, resp_data, r); n_fail++;
    end
    n_checks++;
    @(negedge clk); res_done = 1'b0; if (!keep) req[o] = 1'b0; #1;
    if ({grant, resp_valid} !== 4'b0000) begin
      $display("FAIL %s_idle: grant/valid got %b expected 0000", tag, {grant, resp_valid}); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    if ({grant, res_start, res_data, resp_valid, timeout, st} !== '0) begin
      $display("FAIL reset_outputs: got grant=%b start=%b data=%h valid=%b to=%b expected all 0", grant, res_start, res_data, resp_valid, timeout); n_fail++;
    end
    n_checks++;
    @(negedge clk); reset = 1'b0; model_last = 1;
    @(negedge clk); #1;
    if ({grant, res_start, res_data, resp_valid, timeout} !== '0) begin
      $display("FAIL reset_release: got grant=%b start=%b data=%h expected 0", grant, res_start, res_data); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_single();
    int o, lat;
    for (int i = 0; i < 4; i++) begin
      lat = (i == 0) ? 3 : (i == 3) ? int'(LAT) : int'($urandom_range(1, LAT));
      req = 2'b01; #1;
      if ({grant, st} !== 4'b0001) begin
        $display("FAIL single_pre: grant/stall got %b expected 0001", {grant, st}); n_fail++;
      end
      n_checks++;
      serve_op("single", lat, 1'b0, o);
    end
  endtask

  task automatic test_simultaneous();
    int o;
    test_reset();
    req = 2'b11; #1;
    if (st !== 2'b11) begin
      $display("FAIL simul_stall: got %b expected 11", st); n_fail++;
    end
    n_checks++;
    serve_op("simul_first", 2, 1'b0, o);
    serve_op("simul_second", 2, 1'b0, o);
  endtask

  task automatic test_fairness();
    int o;
    req = 2'b11;
    for (int i = 0; i < 6; i++) serve_op("fair", int'($urandom_range(1, LAT)), (i != 5), o);
    req = 2'b00;
  endtask

  task automatic test_owner_flush();
    int o, oth;
    logic [1:0] g;
    req = 2'b11;
    o = exp_winner(req); oth = 1 - o; g = (o == 0) ? 2'b01 : 2'b10;
    @(negedge clk); #1;
    if ({grant, res_start} !== {g, 1'b1}) begin
      $display("FAIL flush_issue: grant/start got %b expected %b", {grant, res_start}, {g, 1'b1}); n_fail++;
    end
    n_checks++;
    model_last = o;
    @(negedge clk); flush[o] = 1'b1; #1;
    if ({st[o], st[oth], resp_valid} !== 4'b0100) begin
      $display("FAIL flush_stall: stall_own/stall_oth/valid got %b expected 0100", {st[o], st[oth], resp_valid}); n_fail++;
    end
    n_checks++;
    @(negedge clk); flush[o] = 1'b0; req[o] = 1'b0; #1;
    if ({grant, st[oth]} !== {g, 1'b1}) begin
      $display("FAIL flush_drain: grant/stall_oth got %b expected %b", {grant, st[oth]}, {g, 1'b1}); n_fail++;
    end
    n_checks++;
    @(negedge clk); res_done = 1'b1; res_result = $urandom; #1;
    if ({grant, resp_valid} !== {g, 2'b00}) begin
      $display("FAIL flush_discard: grant/valid got %b expected %b", {grant, resp_valid}, {g, 2'b00}); n_fail++;
    end
    n_checks++;
    @(negedge clk); res_done = 1'b0; #1;
    if (grant !== 2'b00) begin
      $display("FAIL flush_exit: grant got %b expected 00", grant); n_fail++;
    end
    n_checks++;
    serve_op("flush_other", int'($urandom_range(1, LAT)), 1'b0, oth);
    // Flush and completion in the same cycle: the result is dropped.
    req = 2'b01;
    o = exp_winner(req);
    @(negedge clk); #1;
    model_last = o;
    @(negedge clk); flush[0] = 1'b1; res_done = 1'b1; #1;
    if ({resp_valid, st[0]} !== 3'b000) begin
      $display("FAIL flush_done_same: valid/stall got %b expected 000", {resp_valid, st[0]}); n_fail++;
    end
    n_checks++;
    @(negedge clk); flush = '0; res_done = 1'b0; req = '0; #1;
    if (grant !== 2'b00) begin
      $display("FAIL flush_done_idle: grant got %b expected 00", grant); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_nonowner_flush();
    int fav, o;
    req = 2'b11;
    fav = exp_winner(2'b11);
    flush[fav] = 1'b1;
    serve_op("nonowner_flush", int'($urandom_range(1, LAT)), 1'b0, o);
    if (o == fav) begin
      $display("FAIL nonowner_model: masked requester %0d chosen", fav); n_fail++;
    end
    flush = '0; req = '0;
  endtask

  task automatic test_timeout();
    int o;
    req = 2'b01;
    @(negedge clk); #1;
    if ({grant, res_start} !== 3'b011) begin
      $display("FAIL timeout_issue: grant/start got %b expected 011", {grant, res_start}); n_fail++;
    end
    n_checks++;
    model_last = 0;
    for (int k = 1; k <= int'(LAT); k++) begin
      @(negedge clk); #1;
      if ({timeout, resp_valid, grant} !== {(k == int'(LAT)), 2'b00, 2'b01}) begin
        $display("FAIL timeout_cycle%0d: timeout/valid/grant got %b expected %b", k, {timeout, resp_valid, grant}, {(k == int'(LAT)), 2'b00, 2'b01}); n_fail++;
      end
      n_checks++;
    end
    @(negedge clk); #1;
    if ({grant, timeout} !== 3'b000) begin
      $display("FAIL timeout_idle: grant/timeout got %b expected 000", {grant, timeout}); n_fail++;
    end
    n_checks++;
    serve_op("timeout_regrant", 1, 1'b0, o);
  endtask

  task automatic test_reset_mid_op();
    req = 2'b01; req_data_1 = $urandom;
    @(negedge clk); #1;
    if (grant !== 2'b01) begin
      $display("FAIL rstmid_issue: grant got %b expected 01", grant); n_fail++;
    end
    n_checks++;
    @(negedge clk);
    @(negedge clk); reset = 1'b1; req = '0; #1;
    if ({grant, res_start, res_data, resp_valid, timeout, st} !== '0) begin
      $display("FAIL rstmid_outputs: grant=%b start=%b data=%h valid=%b to=%b stall=%b expected all 0", grant, res_start, res_data, resp_valid, timeout, st); n_fail++;
    end
    n_checks++;
    @(negedge clk); reset = 1'b0; model_last = 1;
    @(negedge clk); res_done = 1'b1; res_result = $urandom; #1;
    if ({grant, resp_valid} !== 4'b0000) begin
      $display("FAIL rstmid_late_done: grant/valid got %b expected 0000", {grant, resp_valid}); n_fail++;
    end
    n_checks++;
    @(negedge clk); res_done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_owner_flush();
    test_nonowner_flush();
    test_timeout();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
